mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port `memory` block (WIDTH×DEPTH, synchronous write, registered read).
- Each requester issues read/write transactions over a valid/ready handshake.
- The arbiter serialises them onto the memory's addr/w_data/w_en/r_en port, then returns a one-cycle response pulse to the originating requester.

Parameters:
- WIDTH, 16, data width; must match memory WIDTH.
- DEPTH, 128, number of memory words; addresses >= DEPTH are rejected.
- ADDR_WIDTH, 7, address width; must match memory ADDR_WIDTH.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset).
- a_valid  input  1  requester A transaction valid.
- a_ready  output  1  A accepted this cycle when a_valid && a_ready.
- a_we  input  1  A: 1 = write, 0 = read.
- a_addr  input  ADDR_WIDTH  A address.
- a_wdata  input  WIDTH  A write data.
- b_valid, b_ready, b_we, b_addr, b_wdata: same as A, for requester B.
- a_rsp_valid  output  1  one-cycle response pulse to A.
- b_rsp_valid  output  1  one-cycle response pulse to B.
- rsp_rdata  output  WIDTH  read data for the current response; 0 for writes and errors.
- rsp_err  output  1  response is an address error (addr >= DEPTH).
- mem_addr  output  ADDR_WIDTH  to memory addr.
- mem_w_data  output  WIDTH  to memory w_data.
- mem_w_en  output  1  to memory w_en.
- mem_r_en  output  1  to memory r_en.
- mem_r_data  input  WIDTH  from memory r_data; valid the cycle after the r_en edge.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, last_grant=B (so A wins the first tie).
  - All outputs 0: mem_*, rsp_*, a/b_rsp_valid.
  - Any in-flight transaction is discarded; no response is ever issued for it.
- FSM states: IDLE, ISSUE, WAIT. Fixed sequence IDLE→ISSUE→WAIT→IDLE; one transaction per 3 cycles max.
- IDLE:
  - a_ready/b_ready are combinational, asserted only in IDLE, at most one high.
  - Only A valid → grant A. Only B valid → grant B.
  - Both valid → grant the requester not equal to last_grant.
  - Neither valid → both ready low, stay in IDLE.
  - On an accept edge: latch id, we, addr, wdata; update last_grant; go to ISSUE.
- ISSUE (one cycle): registered outputs drive mem_addr = latched addr.
  - Write: mem_w_en=1, mem_w_data = latched wdata.
  - Read: mem_r_en=1.
  - addr >= DEPTH: both enables stay 0 and the err flag is set.
  - mem_w_en and mem_r_en are never both 1.
- WAIT (one cycle):
  - Enables return to 0; mem_addr and mem_w_data are driven to 0.
  - At the end-of-WAIT edge, register the response:
    - rsp_valid of the latched id = 1.
    - rsp_rdata = mem_r_data for a read without error, else 0.
    - rsp_err = err flag.
- Response timing:
  - Response outputs are high for exactly the one cycle after WAIT, which is IDLE; they clear on the next edge.
  - A new accept may occur in that same cycle.
  - Latency: accept edge E0 → response visible in the cycle after E2, for reads, writes and errors alike.
- No response back-pressure: requesters must take the response pulse unconditionally.
- Changes to a_*/b_* inputs after accept have no effect on the transaction in flight.
- A requester that holds valid after being served loses the next tie; a continuously contending pair alternates A,B,A,B.

Test Plan:
- Single writes then reads, A only: write addr 5 data 16'hBEEF → a_ready=1 at accept, mem_w_en=1 with mem_addr=5 one cycle later, a_rsp_valid pulse 3 cycles after accept with rsp_err=0. Then read addr 5 → mem_r_en pulse, a_rsp_valid with rsp_rdata=16'hBEEF.
- Contention: a_valid and b_valid both held high, A writes addr 0..3, B writes addr 64..67 → grants alternate A,B,A,B…, no b_ready/a_ready overlap, 8 responses, each to the correct requester. Read-back of all 8 words matches.
- Full sweep: A writes $random to addr 0..127, then B reads 0..127 → every rsp_rdata equals the written value; addr 127 accepted without error.
- Address error with DEPTH=100: A reads addr 100 and writes addr 120 → mem_r_en/mem_w_en stay 0, a_rsp_valid with rsp_err=1 and rsp_rdata=0. Memory contents at 0..99 unchanged.
- Reset mid-operation: assert rst=0 during ISSUE of a read from B → all outputs 0 immediately, no b_rsp_valid after release. First request after reset with both valid is granted to A.
- Back-to-back: A holds valid for 4 reads → accepts occur every 3 cycles, and each accept coincides with the previous a_rsp_valid pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for two requesters sharing one single-port memory; fixed IDLE->ISSUE->WAIT sequence,
// response pulse in the cycle after the third edge from accept. Ready is offered in IDLE only; responses cannot stall.
module mem_arbiter #(
    parameter int          WIDTH      = 16,
    parameter int unsigned DEPTH      = 128,
    parameter int          ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [WIDTH-1:0]      a_wdata,

    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [WIDTH-1:0]      b_wdata,

    output logic                  a_rsp_valid,
    output logic                  b_rsp_valid,
    output logic [WIDTH-1:0]      rsp_rdata,
    output logic                  rsp_err,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_w_data,
    output logic                  mem_w_en,
    output logic                  mem_r_en,
    input  logic [WIDTH-1:0]      mem_r_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // id: 0 = requester A, 1 = requester B
    typedef struct packed {
        logic id;
        logic we;
        logic err;
    } txn_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    last_grant_q;
    txn_t                    txn_q;
    txn_t                    txn_in;
    logic                    sel_b;
    logic                    accept;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [WIDTH-1:0]        sel_wdata;

    logic [ADDR_WIDTH-1:0]   mem_addr_d;
    logic [WIDTH-1:0]        mem_w_data_d;
    logic                    mem_w_en_d;
    logic                    mem_r_en_d;
    logic                    a_rsp_valid_d;
    logic                    b_rsp_valid_d;
    logic [WIDTH-1:0]        rsp_rdata_d;
    logic                    rsp_err_d;

    // On a tie the requester that was not served last wins.
    always_comb begin
        sel_b     = b_valid && (!a_valid || !last_grant_q);
        a_ready   = rst && (state_q == ST_IDLE) && a_valid && !sel_b;
        b_ready   = rst && (state_q == ST_IDLE) && sel_b;
        accept    = a_ready || b_ready;
        sel_addr  = sel_b ? b_addr  : a_addr;
        sel_wdata = sel_b ? b_wdata : a_wdata;
        txn_in     = '0;
        txn_in.id  = sel_b;
        txn_in.we  = sel_b ? b_we : a_we;
        txn_in.err = ({{(32-ADDR_WIDTH){1'b0}}, sel_addr} >= DEPTH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            txn_q        <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                txn_q        <= txn_in;
                last_grant_q <= txn_in.id;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; the memory port is loaded on the accept edge
    // so the access is on the bus during ISSUE, and the response is captured on the WAIT->IDLE edge.
    always_comb begin
        mem_addr_d    = '0;
        mem_w_data_d  = '0;
        mem_w_en_d    = 1'b0;
        mem_r_en_d    = 1'b0;
        a_rsp_valid_d = 1'b0;
        b_rsp_valid_d = 1'b0;
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    mem_addr_d = sel_addr;
                    mem_w_en_d = txn_in.we && !txn_in.err;
                    mem_r_en_d = !txn_in.we && !txn_in.err;
                    if (txn_in.we && !txn_in.err) mem_w_data_d = sel_wdata;
                end
            end
            ST_WAIT: begin
                a_rsp_valid_d = !txn_q.id;
                b_rsp_valid_d = txn_q.id;
                rsp_err_d     = txn_q.err;
                if (!txn_q.we && !txn_q.err) rsp_rdata_d = mem_r_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr    <= '0;
            mem_w_data  <= '0;
            mem_w_en    <= 1'b0;
            mem_r_en    <= 1'b0;
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            mem_addr    <= mem_addr_d;
            mem_w_data  <= mem_w_data_d;
            mem_w_en    <= mem_w_en_d;
            mem_r_en    <= mem_r_en_d;
            a_rsp_valid <= a_rsp_valid_d;
            b_rsp_valid <= b_rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_err     <= rsp_err_d;
        end
    end

    en_exclusive: assert property (@(posedge clk) disable iff (!rst) !(mem_w_en && mem_r_en));
    rdy_exclusive: assert property (@(posedge clk) disable iff (!rst) !(a_ready && b_ready));
    rsp_exclusive: assert property (@(posedge clk) disable iff (!rst) !(a_rsp_valid && b_rsp_valid));
    issue_then_wait: assert property (@(posedge clk) disable iff (!rst)
        (state_q == ST_ISSUE) |=> (state_q == ST_WAIT));

endmodule

// File: tb/tb_mem_arbiter.sv
// Random and directed traffic into two arbiters (DEPTH 128 and DEPTH 100) sharing one stimulus,
// each backed by its own behavioural memory and checked against a transaction-timeline model.
module tb_mem_arbiter;
    localparam int W      = 16;
    localparam int AW     = 7;
    localparam int DEPTH0 = 128;
    localparam int DEPTH1 = 100;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } req_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          a_valid, a_we, b_valid, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [W-1:0]  a_wdata, b_wdata;

    logic          a_ready0, b_ready0, a_rsp0, b_rsp0, err0, w_en0, r_en0;
    logic [W-1:0]  rdata0, w_data0, r_data0;
    logic [AW-1:0] addr0;
    logic          a_ready1, b_ready1, a_rsp1, b_rsp1, err1, w_en1, r_en1;
    logic [W-1:0]  rdata1, w_data1, r_data1;
    logic [AW-1:0] addr1;

    mem_arbiter #(.WIDTH(W), .DEPTH(DEPTH0), .ADDR_WIDTH(AW)) dut0 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready0), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_ready(b_ready0), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_rsp_valid(a_rsp0), .b_rsp_valid(b_rsp0), .rsp_rdata(rdata0), .rsp_err(err0),
        .mem_addr(addr0), .mem_w_data(w_data0), .mem_w_en(w_en0), .mem_r_en(r_en0),
        .mem_r_data(r_data0)
    );

    mem_arbiter #(.WIDTH(W), .DEPTH(DEPTH1), .ADDR_WIDTH(AW)) dut1 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready1), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_ready(b_ready1), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_rsp_valid(a_rsp1), .b_rsp_valid(b_rsp1), .rsp_rdata(rdata1), .rsp_err(err1),
        .mem_addr(addr1), .mem_w_data(w_data1), .mem_w_en(w_en1), .mem_r_en(r_en1),
        .mem_r_data(r_data1)
    );

    // Single-port memories: synchronous write, registered read.
    logic [W-1:0] bmem0 [128];
    logic [W-1:0] bmem1 [128];
    always @(posedge clk) begin
        if (w_en0) bmem0[addr0] <= w_data0;
        if (r_en0) r_data0 <= bmem0[addr0];
        if (w_en1) bmem1[addr1] <= w_data1;
        if (r_en1) r_data1 <= bmem1[addr1];
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Model: a new accept is possible 3 cycles after the previous one; the memory access
    // appears 1 cycle after accept and the response 3 cycles after accept.
    int            cyc;
    int            last_acc;
    logic          model_last;
    logic          pend_vld;
    int            pend_acc;
    logic          pend_id, pend_we, pend_ok0, pend_ok1;
    logic [AW-1:0] pend_addr;
    logic [W-1:0]  pend_wdata, pend_rd0, pend_rd1;
    logic [W-1:0]  ref0 [128];
    logic [W-1:0]  ref1 [128];
    req_t          qa[$];
    req_t          qb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic req_t mk(input logic we, input int addr, input logic [W-1:0] data);
        req_t r;
        r.we   = we;
        r.addr = AW'(addr);
        r.data = data;
        return r;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl0"}, 32'({a_ready0, b_ready0, a_rsp0, b_rsp0, err0, w_en0, r_en0}), 32'd0);
        chk({tag, "_addr0"}, 32'(addr0), 32'd0);
        chk({tag, "_wd0"}, 32'(w_data0), 32'd0);
        chk({tag, "_rd0"}, 32'(rdata0), 32'd0);
        chk({tag, "_ctl1"}, 32'({a_ready1, b_ready1, a_rsp1, b_rsp1, err1, w_en1, r_en1}), 32'd0);
        chk({tag, "_addr1"}, 32'(addr1), 32'd0);
        chk({tag, "_wd1"}, 32'(w_data1), 32'd0);
        chk({tag, "_rd1"}, 32'(rdata1), 32'd0);
    endtask

    task automatic chk_mem(input string tag, input logic issue, input logic ok,
                           input logic w_en, input logic r_en, input logic [AW-1:0] addr,
                           input logic [W-1:0] wd);
        chk({tag, "_ctl"}, 32'({w_en, r_en, addr}),
            issue ? 32'({pend_we && ok, !pend_we && ok, pend_addr}) : 32'd0);
        if (!issue) chk({tag, "_wd"}, 32'(wd), 32'd0);
        else if (pend_we && ok) chk({tag, "_wd"}, 32'(wd), 32'(pend_wdata));
    endtask

    task automatic chk_rsp(input string tag, input logic rsp, input logic ok, input logic [W-1:0] rd_exp,
                           input logic a_r, input logic b_r, input logic e, input logic [W-1:0] rd);
        chk(tag, 32'({a_r, b_r, e, rd}), rsp ? 32'({!pend_id, pend_id, !ok, rd_exp}) : 32'd0);
    endtask

    task automatic accept_model(input req_t r, input logic id);
        model_last = id;
        last_acc   = cyc;
        pend_vld   = 1'b1;
        pend_acc   = cyc;
        pend_id    = id;
        pend_we    = r.we;
        pend_addr  = r.addr;
        pend_wdata = r.data;
        pend_ok0   = (int'(r.addr) < DEPTH0);
        pend_ok1   = (int'(r.addr) < DEPTH1);
        pend_rd0   = (!r.we && pend_ok0) ? ref0[r.addr] : '0;
        pend_rd1   = (!r.we && pend_ok1) ? ref1[r.addr] : '0;
        if (r.we && pend_ok0) ref0[r.addr] = r.data;
        if (r.we && pend_ok1) ref1[r.addr] = r.data;
    endtask

    task automatic step();
        logic issue, rsp, idle, ea, eb;
        req_t r;
        @(negedge clk);
        cyc++;
        issue = pend_vld && (cyc == pend_acc + 1);
        rsp   = pend_vld && (cyc == pend_acc + 3);
        chk_mem("mem0", issue, pend_ok0, w_en0, r_en0, addr0, w_data0);
        chk_mem("mem1", issue, pend_ok1, w_en1, r_en1, addr1, w_data1);
        chk_rsp("rsp0", rsp, pend_ok0, pend_rd0, a_rsp0, b_rsp0, err0, rdata0);
        chk_rsp("rsp1", rsp, pend_ok1, pend_rd1, a_rsp1, b_rsp1, err1, rdata1);
        if (rsp) pend_vld = 1'b0;

        // Idle requesters wiggle their payload to show it is ignored.
        if (qa.size() > 0) begin
            r = qa[0];
            a_valid = 1'b1; a_we = r.we; a_addr = r.addr; a_wdata = r.data;
        end else begin
            a_valid = 1'b0; a_we = 1'($urandom); a_addr = AW'($urandom); a_wdata = W'($urandom);
        end
        if (qb.size() > 0) begin
            r = qb[0];
            b_valid = 1'b1; b_we = r.we; b_addr = r.addr; b_wdata = r.data;
        end else begin
            b_valid = 1'b0; b_we = 1'($urandom); b_addr = AW'($urandom); b_wdata = W'($urandom);
        end
        #1;
        idle = (cyc >= last_acc + 3);
        ea   = idle && a_valid && (!b_valid || model_last);
        eb   = idle && b_valid && (!a_valid || !model_last);
        chk("rdy0", 32'({a_ready0, b_ready0}), 32'({ea, eb}));
        chk("rdy1", 32'({a_ready1, b_ready1}), 32'({ea, eb}));
        if (ea) begin
            r = qa.pop_front();
            accept_model(r, 1'b0);
        end else if (eb) begin
            r = qb.pop_front();
            accept_model(r, 1'b1);
        end
    endtask

    task automatic run(input int budget);
        int n = 0;
        while ((qa.size() > 0 || qb.size() > 0 || pend_vld) && n < budget) begin
            step();
            n++;
        end
        chk("budget", 32'(qa.size() + qb.size() + int'(pend_vld)), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        a_valid = 1'b1; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_valid = 1'b1; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        cyc = 0; last_acc = -100; model_last = 1'b1; pend_vld = 1'b0;
        pend_acc = 0; pend_id = 0; pend_we = 0; pend_ok0 = 0; pend_ok1 = 0;
        pend_addr = '0; pend_wdata = '0; pend_rd0 = '0; pend_rd1 = '0;

        @(negedge clk);
        chk_zero("reset");
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst = 1'b1;

        // Single write then read-back on A.
        qa.push_back(mk(1'b1, 5, 16'hBEEF));
        qa.push_back(mk(1'b0, 5, 16'h0000));
        run(40);

        // Contention: both hold valid, grants must alternate.
        for (int i = 0; i < 4; i++) begin
            qa.push_back(mk(1'b1, i, W'($urandom)));
            qb.push_back(mk(1'b1, 64 + i, W'($urandom)));
        end
        run(100);
        for (int i = 0; i < 4; i++) begin
            qa.push_back(mk(1'b0, i, '0));
            qb.push_back(mk(1'b0, 64 + i, '0));
        end
        run(100);

        // Full sweep: A writes everything, then B reads everything back.
        for (int i = 0; i < 128; i++) qa.push_back(mk(1'b1, i, W'($urandom)));
        run(600);
        for (int i = 0; i < 128; i++) qb.push_back(mk(1'b0, i, '0));
        run(600);

        // Out-of-range accesses for the DEPTH=100 instance, plus the boundary word.
        qa.push_back(mk(1'b0, 100, '0));
        qa.push_back(mk(1'b1, 120, 16'h1234));
        qb.push_back(mk(1'b0, 99, '0));
        qb.push_back(mk(1'b0, 120, '0));
        run(60);

        // A holds valid for four back-to-back reads.
        for (int i = 0; i < 4; i++) qa.push_back(mk(1'b0, $urandom_range(0, 127), '0));
        run(40);

        for (int k = 0; k < 400; k++) begin
            if (qa.size() == 0 && $urandom_range(0, 2) == 0)
                qa.push_back(mk(1'($urandom), $urandom_range(0, 127), W'($urandom)));
            if (qb.size() == 0 && $urandom_range(0, 2) == 0)
                qb.push_back(mk(1'($urandom), $urandom_range(0, 127), W'($urandom)));
            step();
        end
        run(200);

        // Reset during ISSUE of a B read: the transaction must vanish.
        qb.push_back(mk(1'b0, 7, '0));
        for (int n = 0; n < 20 && !(pend_vld && pend_acc == cyc); n++) step();
        step();
        rst = 1'b0;
        #1;
        chk_zero("rst_mid");
        pend_vld = 1'b0;
        last_acc = -100;
        model_last = 1'b1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        @(negedge clk);
        cyc++;
        chk_zero("rst_hold");
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst = 1'b1;
        repeat (5) step();
        qa.push_back(mk(1'b0, 3, '0));
        qb.push_back(mk(1'b0, 4, '0));
        run(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
